// File: rtl/sdram_mon_pkg.sv
// Shared types for the SDRAM protocol monitors: command decode, error codes
// and the init-sequence state encoding.
package sdram_mon_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_PRE,
    CMD_AR,
    CMD_LMR,
    CMD_ILLEGAL
  } cmd_e;

  typedef enum logic [3:0] {
    ERR_NONE        = 4'd0,
    ERR_ILLEGAL_CMD = 4'd1,
    ERR_TRP         = 4'd2,
    ERR_TRFC        = 4'd3,
    ERR_AR_COUNT    = 4'd4,
    ERR_TMRD        = 4'd5,
    ERR_EARLY_DONE  = 4'd6,
    ERR_TIMEOUT     = 4'd7,
    ERR_CKE_LOW     = 4'd8
  } err_e;

  typedef enum logic [2:0] {
    S_WAIT_PRE,
    S_WAIT_AR,
    S_AR_LOOP,
    S_WAIT_DONE,
    S_DONE,
    S_ERROR
  } state_e;

  // {cs_n,ras_n,cas_n,we_n}; deselect is a NOP regardless of the other pins
  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    cmd_e c;
    if (cs_n) begin
      c = CMD_NOP;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b111:  c = CMD_NOP;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_AR;
        3'b000:  c = CMD_LMR;
        default: c = CMD_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational SDRAM command-pin decoder, shared by the protocol monitors.
module sdram_cmd_decode
  import sdram_mon_pkg::*;
(
  input  logic i_cs_n,
  input  logic i_ras_n,
  input  logic i_cas_n,
  input  logic i_we_n,
  output cmd_e o_cmd
);

  assign o_cmd = decode_cmd(i_cs_n, i_ras_n, i_cas_n, i_we_n);

endmodule

// File: rtl/sdram_init_monitor.sv
// Checks the SDRAM power-up sequence (PRE, NUM_AR x AR, LMR, init_done) and
// its tRP/tRFC/tMRD timing; reports a sticky pass or a sticky coded failure.
module sdram_init_monitor
  import sdram_mon_pkg::*;
#(
  parameter int unsigned T_RP       = 3,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned NUM_AR     = 8,
  parameter int unsigned T_MRD      = 2,
  parameter int unsigned T_DONE_MAX = 16,
  parameter int unsigned T_PRE_MAX  = 200,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             sdram_clk,
  input  logic             sdram_resetn,
  input  logic             sdr_cke,
  input  logic             sdr_cs_n,
  input  logic             sdr_ras_n,
  input  logic             sdr_cas_n,
  input  logic             sdr_we_n,
  input  logic             sdr_init_done,
  output logic             init_ok,
  output logic             init_err,
  output logic [3:0]       err_code,
  output logic [CNT_W-1:0] ar_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] L_RP       = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] L_RFC      = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] L_NUM_AR   = CNT_W'(NUM_AR);
  localparam logic [CNT_W-1:0] L_MRD      = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0] L_DONE_MAX = CNT_W'(T_DONE_MAX);
  localparam logic [CNT_W-1:0] L_PRE_MAX  = CNT_W'(T_PRE_MAX);

  cmd_e             w_cmd;
  state_e           r_state;
  err_e             r_err;
  err_e             w_err;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] w_gap;
  logic [CNT_W-1:0] r_ar_cnt;
  logic             r_done_q;
  logic             r_init_ok;
  logic             r_init_err;
  logic             r_busy;
  logic             w_done_rise;
  logic             w_accept;

  sdram_cmd_decode u_cmd_decode (
    .i_cs_n  (sdr_cs_n),
    .i_ras_n (sdr_ras_n),
    .i_cas_n (sdr_cas_n),
    .i_we_n  (sdr_we_n),
    .o_cmd   (w_cmd)
  );

  // w_gap counts edges since the last accepted command, including this edge
  always_comb begin
    w_gap       = (r_gap == '1) ? r_gap : r_gap + 1'b1;
    w_done_rise = sdr_init_done & ~r_done_q;
    w_accept    = (w_cmd == CMD_PRE) || (w_cmd == CMD_AR) || (w_cmd == CMD_LMR);
    w_err       = ERR_NONE;
    // Checks are written lowest priority first so later assignments win
    case (r_state)
      S_WAIT_PRE: begin
        if (w_gap > L_PRE_MAX) w_err = ERR_TIMEOUT;
        if (w_cmd == CMD_AR || w_cmd == CMD_LMR) w_err = ERR_ILLEGAL_CMD;
      end
      S_WAIT_AR: begin
        if (w_cmd == CMD_AR && w_gap < L_RP) w_err = ERR_TRP;
        if (w_cmd == CMD_PRE || w_cmd == CMD_LMR || w_cmd == CMD_ILLEGAL)
          w_err = ERR_ILLEGAL_CMD;
      end
      S_AR_LOOP: begin
        if (w_cmd == CMD_LMR && r_ar_cnt < L_NUM_AR) w_err = ERR_AR_COUNT;
        if ((w_cmd == CMD_AR || w_cmd == CMD_LMR) && w_gap < L_RFC) w_err = ERR_TRFC;
        if (w_cmd == CMD_PRE || w_cmd == CMD_ILLEGAL) w_err = ERR_ILLEGAL_CMD;
      end
      S_WAIT_DONE: begin
        if (w_gap > L_DONE_MAX) w_err = ERR_TIMEOUT;
        if (w_done_rise && w_gap < L_MRD) w_err = ERR_TMRD;
        if (w_cmd != CMD_NOP) w_err = ERR_ILLEGAL_CMD;
      end
      default: ;
    endcase
    if ((r_state == S_WAIT_PRE || r_state == S_WAIT_AR || r_state == S_AR_LOOP)
        && sdr_init_done)
      w_err = ERR_EARLY_DONE;
    if ((r_state == S_WAIT_AR || r_state == S_AR_LOOP || r_state == S_WAIT_DONE)
        && !sdr_cke)
      w_err = ERR_CKE_LOW;
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_state    <= S_WAIT_PRE;
      r_err      <= ERR_NONE;
      r_gap      <= '0;
      r_ar_cnt   <= '0;
      r_done_q   <= 1'b0;
      r_init_ok  <= 1'b0;
      r_init_err <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_done_q <= sdr_init_done;
      r_gap    <= w_accept ? '0 : w_gap;
      if (r_state != S_DONE && r_state != S_ERROR) begin
        if (w_err != ERR_NONE) begin
          r_state    <= S_ERROR;
          r_err      <= w_err;
          r_init_err <= 1'b1;
          r_busy     <= 1'b0;
        end else begin
          case (r_state)
            S_WAIT_PRE:
              if (w_cmd == CMD_PRE) r_state <= S_WAIT_AR;
            S_WAIT_AR:
              if (w_cmd == CMD_AR) begin
                r_ar_cnt <= CNT_W'(1);
                r_state  <= S_AR_LOOP;
              end
            S_AR_LOOP:
              if (w_cmd == CMD_AR) begin
                if (r_ar_cnt != '1) r_ar_cnt <= r_ar_cnt + 1'b1;
              end else if (w_cmd == CMD_LMR) begin
                r_state <= S_WAIT_DONE;
              end
            S_WAIT_DONE:
              if (w_done_rise) begin
                r_state   <= S_DONE;
                r_init_ok <= 1'b1;
                r_busy    <= 1'b0;
              end
            default: ;
          endcase
        end
      end
    end
  end

  assign init_ok  = r_init_ok;
  assign init_err = r_init_err;
  assign err_code = r_err;
  assign ar_count = r_ar_cnt;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed self-checking bench for sdram_init_monitor with default parameters.
module tb_sdram_init_monitor;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_AR  = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_ACT = 4'b0011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cke = 1'b1;
  logic       cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic       init_done = 1'b0;
  logic       init_ok, init_err, busy;
  logic [3:0] err_code;
  logic [7:0] ar_count;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sdram_init_monitor #(
    .T_RP(3), .T_RFC(7), .NUM_AR(8), .T_MRD(2),
    .T_DONE_MAX(16), .T_PRE_MAX(200), .CNT_W(8)
  ) dut (
    .sdram_clk     (clk),
    .sdram_resetn  (rst_n),
    .sdr_cke       (cke),
    .sdr_cs_n      (cs_n),
    .sdr_ras_n     (ras_n),
    .sdr_cas_n     (cas_n),
    .sdr_we_n      (we_n),
    .sdr_init_done (init_done),
    .init_ok       (init_ok),
    .init_err      (init_err),
    .err_code      (err_code),
    .ar_count      (ar_count),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag, input logic ok, input logic err,
                           input logic [3:0] code, input logic [7:0] ar, input logic bsy);
    check({tag, ".init_ok"},  32'(init_ok),  32'(ok));
    check({tag, ".init_err"}, 32'(init_err), 32'(err));
    check({tag, ".err_code"}, 32'(err_code), 32'(code));
    check({tag, ".ar_count"}, 32'(ar_count), 32'(ar));
    check({tag, ".busy"},     32'(busy),     32'(bsy));
  endtask

  task automatic put(input logic [3:0] c);
    {cs_n, ras_n, cas_n, we_n} = c;
  endtask

  // Leaves the bench at the falling edge following rising edge k
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic cmd_at(input int k, input logic [3:0] c);
    go_to(k - 1);
    put(c);
    go_to(k);
    put(C_NOP);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cke       = 1'b1;
    init_done = 1'b0;
    put(C_NOP);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic legal_ars(input int n_ar);
    cmd_at(10, C_PRE);
    for (int i = 0; i < n_ar; i++) cmd_at(13 + 7 * i, C_AR);
  endtask

  initial begin
    // reset values while reset is held
    rst_n = 1'b0;
    #12;
    check_all("reset", 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);

    // 1: legal sequence
    do_reset();
    legal_ars(8);
    check("t1.ar_after_8", 32'(ar_count), 32'd8);
    cmd_at(69, C_LMR);
    go_to(71);
    init_done = 1'b1;
    check_all("t1.before_done", 1'b0, 1'b0, 4'd0, 8'd8, 1'b1);
    go_to(72);
    check_all("t1.done", 1'b1, 1'b0, 4'd0, 8'd8, 1'b0);
    put(C_ACT);
    cke = 1'b0;
    go_to(75);
    check_all("t1.done_sticky", 1'b1, 1'b0, 4'd0, 8'd8, 1'b0);

    // 2: tRP violation
    do_reset();
    cmd_at(10, C_PRE);
    go_to(11);
    check("t2.no_err_yet", 32'(init_err), 32'd0);
    cmd_at(12, C_AR);
    check_all("t2.trp", 1'b0, 1'b1, 4'd2, 8'd0, 1'b0);

    // tRFC violation: second AR one cycle early
    do_reset();
    cmd_at(10, C_PRE);
    cmd_at(13, C_AR);
    cmd_at(19, C_AR);
    check_all("trfc", 1'b0, 1'b1, 4'd3, 8'd1, 1'b0);

    // 3: too few ARs
    do_reset();
    legal_ars(5);
    check("t3.ar5", 32'(ar_count), 32'd5);
    cmd_at(48, C_LMR);
    check_all("t3.ar_count_err", 1'b0, 1'b1, 4'd4, 8'd5, 1'b0);

    // 4a: init_done never rises -> timeout exactly at LMR+17
    do_reset();
    legal_ars(8);
    cmd_at(69, C_LMR);
    go_to(85);
    check_all("t4.at_max", 1'b0, 1'b0, 4'd0, 8'd8, 1'b1);
    go_to(86);
    check_all("t4.timeout", 1'b0, 1'b1, 4'd7, 8'd8, 1'b0);

    // 4b: init_done at LMR+1 -> tMRD
    do_reset();
    legal_ars(8);
    cmd_at(69, C_LMR);
    init_done = 1'b1;
    go_to(70);
    check_all("t4.tmrd", 1'b0, 1'b1, 4'd5, 8'd8, 1'b0);

    // init_done exactly at LMR+T_DONE_MAX still passes
    do_reset();
    legal_ars(8);
    cmd_at(69, C_LMR);
    go_to(84);
    init_done = 1'b1;
    go_to(85);
    check_all("done_at_max", 1'b1, 1'b0, 4'd0, 8'd8, 1'b0);

    // 5a: ACT in AR_LOOP
    do_reset();
    legal_ars(2);
    cmd_at(25, C_ACT);
    check_all("t5.illegal", 1'b0, 1'b1, 4'd1, 8'd2, 1'b0);

    // 5b: ACT plus CKE low on the same edge -> CKE_LOW wins
    do_reset();
    legal_ars(2);
    go_to(24);
    cke = 1'b0;
    put(C_ACT);
    go_to(25);
    put(C_NOP);
    cke = 1'b1;
    check_all("t5.cke", 1'b0, 1'b1, 4'd8, 8'd2, 1'b0);
    go_to(28);
    check("t5.sticky_code", 32'(err_code), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    check_all("t5.async_rst", 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);

    // 5c: rerun after reset passes
    do_reset();
    legal_ars(8);
    cmd_at(69, C_LMR);
    go_to(71);
    init_done = 1'b1;
    go_to(72);
    check_all("t5.rerun", 1'b1, 1'b0, 4'd0, 8'd8, 1'b0);

    // 6a: init_done high while waiting for PRE
    do_reset();
    go_to(4);
    init_done = 1'b1;
    go_to(5);
    check_all("t6.early_done", 1'b0, 1'b1, 4'd6, 8'd0, 1'b0);

    // 6b: no PRE at all
    do_reset();
    go_to(200);
    check_all("t6.pre_at_max", 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    go_to(201);
    check_all("t6.pre_timeout", 1'b0, 1'b1, 4'd7, 8'd0, 1'b0);

    // LMR before PRE
    do_reset();
    cmd_at(5, C_LMR);
    check("pre_order", 32'(err_code), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
- Synthesizable, parametrised checker for the SDRAM power-up sequence, placed beside the SDRAM controller on the sdram_clk domain.
- Decodes the cs_n/ras_n/cas_n/we_n command bus and enforces the order PRECHARGE, then NUM_AR AUTO_REFRESH, then LOAD_MODE_REGISTER, then sdr_init_done.
- Checks tRP, tRFC and tMRD against parameters and applies timeouts.
- Reports a sticky pass flag, or a sticky fail flag with an error code; usable in FPGA/emulation as well as simulation.

Parameters:
T_RP, 3, minimum cycles from PRECHARGE edge to first AUTO_REFRESH edge
T_RFC, 7, minimum cycles between AUTO_REFRESH edges, and from last AUTO_REFRESH to LMR
NUM_AR, 8, minimum AUTO_REFRESH count before LMR
T_MRD, 2, minimum cycles from LMR edge to sdr_init_done rising
T_DONE_MAX, 16, maximum cycles from LMR to sdr_init_done rising
T_PRE_MAX, 200, maximum cycles from reset release to PRECHARGE
CNT_W, 8, width of gap and refresh counters; must hold max(T_PRE_MAX, T_DONE_MAX) + 1

Ports:
sdram_clk  in  1  monitor clock
sdram_resetn  in  1  asynchronous active-low reset
sdr_cke  in  1  SDRAM clock enable
sdr_cs_n  in  1  chip select
sdr_ras_n  in  1  RAS
sdr_cas_n  in  1  CAS
sdr_we_n  in  1  write enable
sdr_init_done  in  1  controller init-complete flag
init_ok  out  1  sticky pass
init_err  out  1  sticky fail
err_code  out  4  error cause; 0 while no error
ar_count  out  CNT_W  AUTO_REFRESH commands counted, saturating
busy  out  1  1 while sequence is in progress

Behaviour:
- Reset is asynchronous and active-low on sdram_resetn; one clock, sdram_clk, rising edge.
- Reset values: init_ok=0, init_err=0, err_code=0, ar_count=0, busy=1, state=WAIT_PRE, gap counter=0.
- Command decode, as {cs_n,ras_n,cas_n,we_n}:
  - cs_n=1 or 0111: NOP
  - 0010: PRE
  - 0001: AR
  - 0000: LMR
  - anything else (ACT, RD, WR, BST): ILLEGAL
- Gap counter: cleared on each accepted command, otherwise increments and saturates at 2^CNT_W-1. A gap is the number of edges between two command edges.
- FSM:
  - WAIT_PRE: NOP stays. PRE goes to WAIT_AR. AR or LMR gives ILLEGAL_CMD(1). Gap > T_PRE_MAX gives TIMEOUT(7).
  - WAIT_AR: AR with gap < T_RP gives TRP(2). AR with gap >= T_RP sets ar_count=1 and goes to AR_LOOP. PRE, LMR or ILLEGAL gives code 1.
  - AR_LOOP:
    - AR with gap < T_RFC gives TRFC(3); otherwise ar_count++.
    - LMR with gap < T_RFC gives code 3.
    - LMR with ar_count < NUM_AR gives AR_COUNT(4).
    - Otherwise LMR goes to WAIT_DONE.
    - PRE or ILLEGAL gives code 1.
  - WAIT_DONE:
    - sdr_init_done rise with gap < T_MRD gives TMRD(5).
    - sdr_init_done rise with gap in [T_MRD, T_DONE_MAX] goes to DONE.
    - Any non-NOP command gives code 1.
    - Gap > T_DONE_MAX gives code 7.
  - DONE: init_ok=1, busy=0. Inputs are ignored until reset.
  - ERROR: init_err=1, err_code latched, busy=0. Sticky until reset.
- sdr_init_done=1 in any state before WAIT_DONE gives EARLY_DONE(6).
- sdr_cke=0 in any state after PRE has been accepted and before DONE gives CKE_LOW(8).
- Priority when several errors occur on one edge: 8 > 6 > 1 > 2/3/5 > 4 > 7. Only the first error is latched.
- Latency: all outputs are registered and update on the edge that samples the violating or completing event; they are visible the following cycle.
- Reset asserted mid-sequence or in DONE/ERROR: immediate asynchronous return to reset values; the sequence restarts on release.

Decomposition:
- Package sdram_mon_pkg:
  - cmd_e: NOP, PRE, AR, LMR, ILLEGAL
  - err_e 4-bit codes 0 to 8
  - state_e
  - function decode_cmd
- Sub-module sdram_cmd_decode: registered-free combinational decode of the command pins to cmd_e, also reused by future read/write protocol monitors.

Test Plan:
1. Defaults, legal sequence: PRE@10, AR@13,20,27,...,62 (8 ARs, gap 7), LMR@69, init_done rises @72 -> init_ok=1, ar_count=8, err_code=0, busy=0 from cycle 73.
2. AR@12 after PRE@10 (gap 2 < T_RP=3) -> init_err=1, err_code=2, ar_count=0.
3. 5 legal ARs then LMR with gap 7 -> err_code=4, ar_count=5.
4. LMR legal, init_done held low -> err_code=7 exactly at LMR+17; init_done rise at LMR+1 on a separate run -> err_code=5.
5. ACT (0011) during AR_LOOP -> err_code=1; same edge also drives sdr_cke=0 -> err_code=8. Pulse sdram_resetn low mid-ERROR -> all outputs at reset values; legal rerun passes.
6. sdr_init_done=1 while in WAIT_PRE -> err_code=6. No PRE for 201 cycles after reset -> err_code=7.
